// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants, lock FSM states and coordinate types
package vga_timing_pkg;

    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BACK      = 48;
    localparam int VGA_H_DISP      = 640;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BACK      = 33;
    localparam int VGA_V_DISP      = 480;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_LOCK_FRAMES = 2;

    localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_H_ACT_END   = VGA_H_ACT_START + VGA_H_DISP;
    localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;
    localparam int VGA_V_ACT_END   = VGA_V_ACT_START + VGA_V_DISP;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;

    localparam coord_t COORD_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } sync_state_t;

    // Counters never wrap: a runaway line or frame parks at COORD_MAX.
    function automatic coord_t sat_inc(input coord_t c);
        return (c == COORD_MAX) ? c : c + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_receiver_if.sv
// rtl/vga_sync_receiver_if.sv - VGA pin bundle in, coordinate-tagged pixel stream out
interface vga_sync_receiver_if;
    import vga_timing_pkg::*;

    logic   vga_hs;
    logic   vga_vs;
    rgb_t   vga_rgb;
    logic   pixel_valid;
    rgb_t   pixel_data;
    coord_t pixel_xpos;
    coord_t pixel_ypos;
    logic   frame_start;

    modport master (
        output vga_hs, vga_vs, vga_rgb,
        input  pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start
    );

    modport slave (
        input  vga_hs, vga_vs, vga_rgb,
        output pixel_valid, pixel_data, pixel_xpos, pixel_ypos, frame_start
    );

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - input registers for the VGA pins and hsync falling-edge detect
module vga_sync_edge import vga_timing_pkg::*; (
    input  logic vga_clk,
    input  logic sys_rst,
    input  logic vga_hs,
    input  logic vga_vs,
    input  rgb_t vga_rgb,
    output logic s1_vs,
    output rgb_t s1_rgb,
    output logic hs_fall
);

    logic s1_hs;
    logic s2_hs;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s1_hs  <= 1'b0;
            s2_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_rgb <= '0;
        end else begin
            s1_hs  <= vga_hs;
            s2_hs  <= s1_hs;
            s1_vs  <= vga_vs;
            s1_rgb <= vga_rgb;
        end
    end

    // Flags the stage-1 sample that is the first low hsync sample of a line.
    assign hs_fall = s2_hs & ~s1_hs;

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers VGA position from sync edges, measures timing, locks and emits pixels
module vga_sync_receiver import vga_timing_pkg::*; #(
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int H_DISP      = VGA_H_DISP,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int V_DISP      = VGA_V_DISP,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic                vga_clk,
    input  logic                sys_rst,
    vga_sync_receiver_if.slave  vif,
    output logic                locked,
    output logic                sync_err,
    output coord_t              meas_h_total,
    output coord_t              meas_v_total
);

    localparam coord_t H_ACT_START = coord_t'(H_SYNC + H_BACK);
    localparam coord_t H_ACT_END   = coord_t'(H_SYNC + H_BACK + H_DISP);
    localparam coord_t V_ACT_START = coord_t'(V_SYNC + V_BACK);
    localparam coord_t V_ACT_END   = coord_t'(V_SYNC + V_BACK + V_DISP);
    localparam coord_t H_TOTAL_C   = coord_t'(H_TOTAL);
    localparam coord_t V_TOTAL_C   = coord_t'(V_TOTAL);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    logic   s1_vs;
    rgb_t   s1_rgb;
    logic   hs_fall;

    vga_sync_edge u_edge (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .vga_hs  (vif.vga_hs),
        .vga_vs  (vif.vga_vs),
        .vga_rgb (vif.vga_rgb),
        .s1_vs   (s1_vs),
        .s1_rgb  (s1_rgb),
        .hs_fall (hs_fall)
    );

    coord_t      h_q, h_cur, h_len;
    coord_t      v_q, v_cur, v_len;
    logic        line_seen, frame_seen, vs_prev, h_sat_flag;
    logic        vs_start, line_err, sat_err, frame_err, err;
    logic        act;
    sync_state_t state_q, state_d;
    logic [3:0]  match_q, match_d;

    // h_cur/v_cur index the current stage-1 sample; h_q/v_q hold the previous one.
    always_comb begin
        h_cur    = hs_fall ? '0 : sat_inc(h_q);
        h_len    = sat_inc(h_q);
        vs_start = hs_fall & ~s1_vs & vs_prev;
        v_len    = sat_inc(v_q);
        v_cur    = v_q;
        if (hs_fall) begin
            v_cur = vs_start ? '0 : sat_inc(v_q);
        end
        line_err  = hs_fall & line_seen & (h_len != H_TOTAL_C);
        sat_err   = (h_cur == COORD_MAX) & ~h_sat_flag;
        frame_err = vs_start & frame_seen & (v_len != V_TOTAL_C);
        err       = line_err | sat_err | frame_err;
        act       = locked
                  & (h_cur >= H_ACT_START) & (h_cur < H_ACT_END)
                  & (v_cur >= V_ACT_START) & (v_cur < V_ACT_END);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_q          <= '0;
            v_q          <= '0;
            line_seen    <= 1'b0;
            frame_seen   <= 1'b0;
            vs_prev      <= 1'b0;
            h_sat_flag   <= 1'b0;
            meas_h_total <= '0;
            meas_v_total <= '0;
            sync_err     <= 1'b0;
        end else begin
            h_q      <= h_cur;
            v_q      <= v_cur;
            sync_err <= err;
            if (hs_fall) begin
                line_seen <= 1'b1;
                vs_prev   <= s1_vs;
                if (line_seen) begin
                    meas_h_total <= h_len;
                end
            end
            // One saturation error per runaway line; rearmed by the next hsync edge.
            if (hs_fall) begin
                h_sat_flag <= 1'b0;
            end else if (sat_err) begin
                h_sat_flag <= 1'b1;
            end
            if (vs_start) begin
                frame_seen <= 1'b1;
                if (frame_seen) begin
                    meas_v_total <= v_len;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q <= SEARCH;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_start && !err) begin
                    state_d = TRACK;
                    match_d = '0;
                end
            end
            TRACK: begin
                if (err) begin
                    state_d = SEARCH;
                end else if (vs_start) begin
                    match_d = match_q + 4'd1;
                    if (match_q + 4'd1 == LOCK_N) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            locked          <= 1'b0;
            vif.pixel_valid <= 1'b0;
            vif.pixel_data  <= '0;
            vif.pixel_xpos  <= '0;
            vif.pixel_ypos  <= '0;
            vif.frame_start <= 1'b0;
        end else begin
            locked          <= (state_q == LOCKED);
            vif.pixel_valid <= act;
            vif.pixel_data  <= act ? s1_rgb : '0;
            vif.pixel_xpos  <= act ? h_cur - H_ACT_START : '0;
            vif.pixel_ypos  <= act ? v_cur - V_ACT_START : '0;
            vif.frame_start <= act & (h_cur == H_ACT_START) & (v_cur == V_ACT_START);
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench driving a reduced-size VGA timing generator into the receiver
module tb_vga_sync_receiver;
    import vga_timing_pkg::*;

    localparam int HS = 4, HB = 3, HD = 8, HT = 20;
    localparam int VS = 2, VB = 2, VD = 5, VT = 12;
    localparam int XA = HS + HB, YA = VS + VB;

    logic   vga_clk = 1'b0;
    logic   sys_rst = 1'b1;
    logic   locked, sync_err;
    coord_t meas_h_total, meas_v_total;

    vga_sync_receiver_if vif();

    vga_sync_receiver #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk      (vga_clk),
        .sys_rst      (sys_rst),
        .vif          (vif),
        .locked       (locked),
        .sync_err     (sync_err),
        .meas_h_total (meas_h_total),
        .meas_v_total (meas_v_total)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0, gh = 0, gv = 0, cur_len = HT, cur_vt = VT;
    bit pause = 0, mark = 0, chk_data = 1;
    int npix = 0, nfs = 0, nerr = 0, bad_data = 0, bad_unlocked = 0;
    int err_cyc = 0, fall_cyc = 0, rise_cyc = 0, fs_obs_cyc = 0, origin_cyc = 0;
    logic [11:0] fs_data = '0;
    logic prev_locked = 1'b0;
    int fs_q[$];
    int checks = 0, passed = 0;

    // One clock: sample DUT outputs 1 time unit after the edge, then drive the next pin values.
    task automatic step();
        @(posedge vga_clk);
        #1;
        cyc++;
        if (vif.pixel_valid) begin
            npix++;
            if (!locked) bad_unlocked++;
            if (chk_data && vif.pixel_data !== {vif.pixel_xpos[5:0], vif.pixel_ypos[5:0]}) bad_data++;
        end
        if (vif.frame_start) begin
            nfs++;
            fs_obs_cyc = cyc;
            fs_data = vif.pixel_data;
        end
        if (sync_err) begin
            nerr++;
            err_cyc = cyc;
        end
        if (prev_locked && !locked) fall_cyc = cyc;
        if (!prev_locked && locked) rise_cyc = cyc;
        prev_locked = locked;

        if (gh == 0 && gv == 0 && !pause) fs_q.push_back(cyc);
        vif.vga_hs = pause ? 1'b1 : (gh >= HS);
        vif.vga_vs = (gv >= VS);
        if (gh >= XA && gh < XA + HD && gv >= YA && gv < YA + VD) begin
            vif.vga_rgb = {6'(gh - XA), 6'(gv - YA)};
            if (mark && gh == XA && gv == YA) begin
                vif.vga_rgb = 12'hA5C;
                origin_cyc = cyc;
            end
        end else begin
            vif.vga_rgb = '0;
        end
        if (!pause) begin
            if (gh >= cur_len - 1) begin
                gh = 0;
                cur_len = HT;
                if (gv >= cur_vt - 1) begin
                    gv = 0;
                    cur_vt = VT;
                end else begin
                    gv++;
                end
            end else begin
                gh++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_frame_start();
        for (int i = 0; i < 2 * HT * VT && !(gh == 0 && gv == 0); i++) step();
    endtask

    task automatic wait_lock(input string name);
        int n = 0;
        int ref_cyc;
        while (!locked && n < 1500) begin
            step();
            n++;
        end
        checks++;
        if (locked !== 1'b1) $display("FAIL %s: locked=%0b after %0d cycles, required 1", name, locked, n);
        else passed++;
        ref_cyc = (fs_q.size() > 2) ? fs_q[2] : -100;
        checks++;
        if (rise_cyc - ref_cyc != 3)
            $display("FAIL %s_third_vs: lock rose %0d cycles after third frame start, required 3", name, rise_cyc - ref_cyc);
        else passed++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        run(3);
        checks++;
        if (vif.pixel_valid !== 1'b0) $display("FAIL rst_valid: got %0b required 0", vif.pixel_valid); else passed++;
        checks++;
        if (vif.pixel_data !== 12'h000) $display("FAIL rst_data: got %h required 000", vif.pixel_data); else passed++;
        checks++;
        if (vif.frame_start !== 1'b0) $display("FAIL rst_fs: got %0b required 0", vif.frame_start); else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL rst_locked: got %0b required 0", locked); else passed++;
        checks++;
        if (sync_err !== 1'b0) $display("FAIL rst_err: got %0b required 0", sync_err); else passed++;
        checks++;
        if (meas_h_total !== 11'd0 || meas_v_total !== 11'd0)
            $display("FAIL rst_meas: got h=%0d v=%0d required 0/0", meas_h_total, meas_v_total);
        else passed++;
    endtask

    task automatic test_lock();
        fs_q.delete();
        sys_rst = 1'b0;
        wait_lock("lock");
        checks++;
        if (meas_h_total !== 11'(HT)) $display("FAIL lock_meas_h: got %0d required %0d", meas_h_total, HT); else passed++;
        checks++;
        if (meas_v_total !== 11'(VT)) $display("FAIL lock_meas_v: got %0d required %0d", meas_v_total, VT); else passed++;
    endtask

    task automatic test_frame();
        run_to_frame_start();
        npix = 0; nfs = 0; nerr = 0; bad_data = 0;
        run(HT * VT);
        checks++;
        if (npix != HD * VD) $display("FAIL frame_pixels: got %0d required %0d", npix, HD * VD); else passed++;
        checks++;
        if (nfs != 1) $display("FAIL frame_starts: got %0d required 1", nfs); else passed++;
        checks++;
        if (bad_data != 0) $display("FAIL frame_data: %0d bad pixels, required 0", bad_data); else passed++;
        checks++;
        if (nerr != 0) $display("FAIL frame_errs: got %0d required 0", nerr); else passed++;
    endtask

    task automatic test_short_line();
        run_to_frame_start();
        run(HT * 5);
        cur_len = HT - 1;
        nerr = 0; err_cyc = 0; fall_cyc = 0;
        run(25);
        checks++;
        if (meas_h_total !== 11'(HT - 1)) $display("FAIL short_meas_h: got %0d required %0d", meas_h_total, HT - 1); else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL short_locked: got %0b required 0", locked); else passed++;
        checks++;
        if (fall_cyc - err_cyc != 1) $display("FAIL short_fall: lock fell %0d cycles after sync_err, required 1", fall_cyc - err_cyc); else passed++;
        fs_q.delete();
        bad_unlocked = 0;
        wait_lock("relock_short");
        checks++;
        if (nerr != 1) $display("FAIL short_errs: got %0d required 1", nerr); else passed++;
        checks++;
        if (bad_unlocked != 0) $display("FAIL short_unlocked_valid: got %0d required 0", bad_unlocked); else passed++;
    endtask

    task automatic test_hs_hold();
        run_to_frame_start();
        run(HT * 2 + 10);
        pause = 1;
        nerr = 0;
        run(3000);
        checks++;
        if (nerr != 1) $display("FAIL hold_errs: got %0d required 1", nerr); else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL hold_locked: got %0b required 0", locked); else passed++;
        pause = 0;
        run(15);
        checks++;
        if (meas_h_total !== 11'd2047) $display("FAIL hold_meas_h: got %0d required 2047", meas_h_total); else passed++;
        fs_q.delete();
        wait_lock("relock_hold");
    endtask

    task automatic test_short_frame();
        run_to_frame_start();
        cur_vt = VT - 1;
        nerr = 0;
        run(HT * (VT - 1) + 10);
        checks++;
        if (nerr != 1) $display("FAIL vshort_errs: got %0d required 1", nerr); else passed++;
        checks++;
        if (meas_v_total !== 11'(VT - 1)) $display("FAIL vshort_meas_v: got %0d required %0d", meas_v_total, VT - 1); else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL vshort_locked: got %0b required 0", locked); else passed++;
        fs_q.delete();
        wait_lock("relock_vshort");
    endtask

    task automatic test_reset_mid();
        run_to_frame_start();
        run(HT * 5 + XA + 3);
        checks++;
        if (vif.pixel_valid !== 1'b1 || vif.pixel_ypos !== 11'd1)
            $display("FAIL mid_pre_valid: got valid=%0b y=%0d required 1/1", vif.pixel_valid, vif.pixel_ypos);
        else passed++;
        sys_rst = 1'b1;
        step();
        checks++;
        if (vif.pixel_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0)
            $display("FAIL mid_rst_flags: got valid=%0b locked=%0b err=%0b required 0/0/0", vif.pixel_valid, locked, sync_err);
        else passed++;
        checks++;
        if (meas_h_total !== 11'd0 || meas_v_total !== 11'd0 || vif.pixel_xpos !== 11'd0)
            $display("FAIL mid_rst_vals: got h=%0d v=%0d x=%0d required 0/0/0", meas_h_total, meas_v_total, vif.pixel_xpos);
        else passed++;
        sys_rst = 1'b0;
        fs_q.delete();
        wait_lock("relock_rst");
    endtask

    task automatic test_skew();
        run_to_frame_start();
        mark = 1; chk_data = 0;
        fs_obs_cyc = 0; origin_cyc = -100;
        run(HT * VT);
        mark = 0; chk_data = 1;
        checks++;
        if (fs_obs_cyc - origin_cyc != 2) $display("FAIL skew_latency: got %0d clocks required 2", fs_obs_cyc - origin_cyc); else passed++;
        checks++;
        if (fs_data !== 12'hA5C) $display("FAIL skew_data: got %h required a5c", fs_data); else passed++;
    endtask

    initial begin
        vif.vga_hs = 1'b1;
        vif.vga_vs = 1'b1;
        vif.vga_rgb = '0;
        test_reset();
        test_lock();
        test_frame();
        test_short_line();
        test_hs_hold();
        test_short_frame();
        test_reset_mid();
        test_skew();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
